i2c_tmp_poller: RTL and testbench

- Autonomous sequencer that drives the byte-level command interface of the existing i2c master core.
- Periodically reads the 16-bit temperature register (reg 0x00) of the on-board ADT7420 sensor (7-bit address 0x4B).
- Sits between the i2c master and an mmio slot. The CPU sees a ready-made temperature word, so firmware no longer issues eight I2C commands per reading.

---
 rtl/i2c_tmp_poller_pkg.sv | 28 ++
 rtl/i2c_tmp_poller_timer.sv | 33 +++
 rtl/i2c_tmp_poller.sv | 159 +++++++++++++++
 tb/tb_i2c_tmp_poller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_tmp_poller_pkg.sv
// Shared types for the temperature poller.
//   i2c_cmd_t    : command codes understood by the i2c master core
//   poll_state_t : sequencer states
//   RD_ACK/NACK  : ack bit sent by the master after a RD byte (m_din[0])
package i2c_pkg;

    typedef enum logic [2:0] {
        CMD_START   = 3'b000,
        CMD_WR      = 3'b001,
        CMD_RD      = 3'b010,
        CMD_STOP    = 3'b011,
        CMD_RESTART = 3'b100
    } i2c_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_RDY,
        ST_FINISH
    } poll_state_t;

    localparam logic RD_ACK  = 1'b0;
    localparam logic RD_NACK = 1'b1;

    localparam logic [2:0] STEP_STOP = 3'd7;

endpackage

// File: rtl/i2c_tmp_poller_timer.sv
// Poll period counter.
//   clk, reset_n : clock / async active-low reset
//   en           : enables counting; low holds the count at zero
//   run          : count only while the sequencer is idle (frozen otherwise)
//   tick         : start request, high on the cycle the count wraps
module poll_timer #(
    parameter int PERIOD_CYC = 10_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic run,
    output logic tick
);

    localparam int CW = (PERIOD_CYC > 2) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYC - 1);

    logic [CW-1:0] cnt;

    assign tick = en && run && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_tmp_poller.sv
// Autonomous ADT7420 temperature poller driving the i2c master command port.
// Runs START / WR addr+W / WR reg / RESTART / WR addr+R / RD(ACK) / RD(NACK) /
// STOP either periodically (en) or on demand (trig) and publishes the result.
//   clk, reset_n      : clock / async active-low reset
//   en, trig          : periodic enable level / immediate read pulse
//   m_ready, m_done_tick, m_ack, m_dout : status from the i2c master
//   m_cmd, m_din, m_wr: registered command interface to the i2c master
//   temp, temp_valid  : last good {MSB,LSB} reading and its update pulse
//   err               : sticky address/register NACK flag
//   busy              : sequence in progress
module i2c_tmp_poller
    import i2c_pkg::*;
#(
    parameter int         PERIOD_CYC = 10_000_000,
    parameter logic [6:0] DEV_ADDR   = 7'h4B,
    parameter logic [7:0] REG_ADDR   = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        trig,
    input  logic        m_ready,
    input  logic        m_done_tick,
    input  logic        m_ack,
    input  logic [7:0]  m_dout,
    output logic [2:0]  m_cmd,
    output logic [7:0]  m_din,
    output logic        m_wr,
    output logic [15:0] temp,
    output logic        temp_valid,
    output logic        err,
    output logic        busy
);

    poll_state_t state, state_nxt;
    logic [2:0]  step, step_nxt;
    logic        issue;
    logic        abort, abort_now, wr_nack;
    logic [7:0]  msb, lsb;
    logic        tick;
    i2c_cmd_t    tbl_cmd;
    logic [7:0]  tbl_din;

    poll_timer #(.PERIOD_CYC(PERIOD_CYC)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .run     (state == ST_IDLE),
        .tick    (tick)
    );

    always_comb begin
        tbl_cmd = CMD_STOP;
        tbl_din = 8'h00;
        case (step)
            3'd0:    tbl_cmd = CMD_START;
            3'd1:    begin tbl_cmd = CMD_WR; tbl_din = {DEV_ADDR, 1'b0}; end
            3'd2:    begin tbl_cmd = CMD_WR; tbl_din = REG_ADDR; end
            3'd3:    tbl_cmd = CMD_RESTART;
            3'd4:    begin tbl_cmd = CMD_WR; tbl_din = {DEV_ADDR, 1'b1}; end
            3'd5:    begin tbl_cmd = CMD_RD; tbl_din = {7'd0, RD_ACK}; end
            3'd6:    begin tbl_cmd = CMD_RD; tbl_din = {7'd0, RD_NACK}; end
            default: tbl_cmd = CMD_STOP;
        endcase
    end

    // Only a NACK on a byte we transmitted aborts; the NACK on the last RD
    // is our own. Folding the same-cycle NACK in lets m_done_tick and the
    // return of m_ready coincide.
    assign wr_nack   = (state == ST_WAIT_RDY) && m_done_tick && m_ack && (tbl_cmd == CMD_WR);
    assign abort_now = abort || wr_nack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            step  <= 3'd0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig || tick) begin
                    state_nxt = ST_ISSUE;
                    step_nxt  = 3'd0;
                end
            end
            ST_ISSUE: begin
                if (m_ready) begin
                    issue     = 1'b1;
                    state_nxt = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (!m_ready) state_nxt = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (m_ready) begin
                    if (step == STEP_STOP) begin
                        state_nxt = ST_FINISH;
                    end else if (abort_now) begin
                        step_nxt  = STEP_STOP;
                        state_nxt = ST_ISSUE;
                    end else begin
                        step_nxt  = step + 3'd1;
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_wr       <= 1'b0;
            m_cmd      <= 3'd0;
            m_din      <= 8'h00;
            temp       <= 16'h0000;
            temp_valid <= 1'b0;
            err        <= 1'b0;
            abort      <= 1'b0;
            msb        <= 8'h00;
            lsb        <= 8'h00;
        end else begin
            m_wr       <= issue;
            temp_valid <= 1'b0;
            if (issue) begin
                m_cmd <= tbl_cmd;
                m_din <= tbl_din;
            end
            if (state == ST_WAIT_RDY && m_done_tick) begin
                if (step == 3'd5) msb <= m_dout;
                if (step == 3'd6) lsb <= m_dout;
                if (wr_nack)      abort <= 1'b1;
            end
            if (state == ST_FINISH) begin
                abort <= 1'b0;
                if (!abort) begin
                    temp       <= {msb, lsb};
                    temp_valid <= 1'b1;
                    err        <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_i2c_tmp_poller.sv
// Bench for i2c_tmp_poller: behavioural i2c master/slave plus a
// transaction-level model of the poller checked on every clock.
module tb_i2c_tmp_poller;

    localparam int P = 100;
    localparam logic [2:0] C_START = 3'b000, C_WR = 3'b001, C_RD = 3'b010,
                           C_STOP = 3'b011, C_RESTART = 3'b100;

    logic        clk = 1'b0, reset_n = 1'b0, en = 1'b0, trig = 1'b0;
    logic        m_ready = 1'b1, m_done_tick = 1'b0, m_ack = 1'b0;
    logic [7:0]  m_dout = 8'h00;
    logic [2:0]  m_cmd;
    logic [7:0]  m_din;
    logic        m_wr, temp_valid, err, busy;
    logic [15:0] temp;

    always #5 clk = ~clk;

    i2c_tmp_poller #(.PERIOD_CYC(P), .DEV_ADDR(7'h4B), .REG_ADDR(8'h00)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .trig(trig),
        .m_ready(m_ready), .m_done_tick(m_done_tick), .m_ack(m_ack), .m_dout(m_dout),
        .m_cmd(m_cmd), .m_din(m_din), .m_wr(m_wr),
        .temp(temp), .temp_valid(temp_valid), .err(err), .busy(busy)
    );

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural master + slave (drives on negedge) -------
    logic [2:0] mq_cmd = 3'd0;
    logic [7:0] mq_din = 8'h00;
    int         mcnt = 0, wr_idx = 0, cur_nack = 0, nack_wr = 0;
    bit         nack_rand = 0, stop_ret = 0;
    logic [7:0] slave_msb = 8'h0C, slave_lsb = 8'h80;

    always @(negedge clk) begin
        m_done_tick = 1'b0;
        stop_ret    = 1'b0;
        if (!reset_n) begin
            m_ready = 1'b1;
            mcnt    = 0;
        end else if (m_wr) begin
            mq_cmd  = m_cmd;
            mq_din  = m_din;
            m_ready = 1'b0;
            mcnt    = 20;
            if (m_cmd == C_START) begin
                wr_idx   = 0;
                cur_nack = nack_rand ? int'($urandom_range(0, 6)) : nack_wr;
            end
            if (m_cmd == C_WR) wr_idx++;
        end else if (!m_ready) begin
            mcnt--;
            if (mcnt == 0) begin
                m_ready = 1'b1;
                if (mq_cmd == C_WR) begin
                    m_done_tick = 1'b1;
                    m_ack       = (wr_idx == cur_nack);
                    m_dout      = 8'($urandom);
                end else if (mq_cmd == C_RD) begin
                    m_done_tick = 1'b1;
                    m_ack       = 1'($urandom_range(0, 1));
                    m_dout      = mq_din[0] ? slave_lsb : slave_msb;
                end else if (mq_cmd == C_STOP) begin
                    stop_ret = 1'b1;
                end
            end
        end
    end

    // ---------------- reference model + per-cycle compare -----------------
    int          cyc = 0, tcnt = 0, sstep = 0;
    bit          m_idle = 1, fin_pend = 0, seq_abort = 0, exp_tv = 0, prev_wr = 0, req;
    logic [15:0] mtemp = 16'h0;
    bit          merr = 0;
    logic [7:0]  got_msb = 8'h0, got_lsb = 8'h0;
    int          wr_count = 0, start_count = 0, tv_count = 0;
    logic [10:0] log_q[$];

    function automatic logic [10:0] step_exp(input int s);
        case (s)
            0: return {C_START, 8'h00};
            1: return {C_WR, 8'h96};
            2: return {C_WR, 8'h00};
            3: return {C_RESTART, 8'h00};
            4: return {C_WR, 8'h97};
            5: return {C_RD, 8'h00};
            6: return {C_RD, 8'h01};
            default: return {C_STOP, 8'h00};
        endcase
    endfunction

    // din is only meaningful for data commands
    function automatic logic [10:0] norm(input logic [10:0] c);
        if (c[10:8] == C_WR || c[10:8] == C_RD) return c;
        return {c[10:8], 8'h00};
    endfunction

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!reset_n) begin
            m_idle = 1; fin_pend = 0; seq_abort = 0; tcnt = 0; mtemp = 16'h0; merr = 0;
            prev_wr = 0;
            chk("reset_outputs", {m_wr, m_cmd, m_din, temp, temp_valid, err, busy}, 32'h0);
        end else begin
            exp_tv = 0;
            if (m_idle) begin
                req  = en && (tcnt == P - 1);
                tcnt = (!en || req) ? 0 : tcnt + 1;
                if (trig || req) begin
                    m_idle = 0; sstep = 0; seq_abort = 0;
                end
            end else if (fin_pend) begin
                fin_pend = 0;
                m_idle   = 1;
                if (!seq_abort) begin
                    mtemp = {got_msb, got_lsb}; merr = 0; exp_tv = 1;
                end else begin
                    merr = 1;
                end
            end else if (stop_ret) begin
                fin_pend = 1;
            end
            if (m_done_tick && mq_cmd == C_WR && m_ack) seq_abort = 1;
            if (m_done_tick && mq_cmd == C_RD) begin
                if (mq_din[0]) got_lsb = m_dout; else got_msb = m_dout;
            end

            chk("busy", busy, !m_idle);
            chk("temp_valid", temp_valid, exp_tv);
            chk("temp", temp, mtemp);
            chk("err", err, merr);
            if (temp_valid) tv_count++;
            if (m_wr) begin
                wr_count++;
                log_q.push_back({m_cmd, m_din});
                chk("wr_single_cycle", prev_wr, 0);
                chk("wr_while_busy", m_idle, 0);
                chk("cmd_seq", norm({m_cmd, m_din}), seq_abort ? {C_STOP, 8'h00} : norm(step_exp(sstep)));
                if (m_cmd == C_START) start_count++;
                sstep++;
            end
            prev_wr = m_wr;
        end
    end

    // ---------------- stimulus -------------------------------------------
    task automatic pulse_trig();
        @(negedge clk); trig = 1'b1;
        @(negedge clk); trig = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk); n++;
        end
        if (n >= budget) chk("timeout_wait_idle", 1, 0);
    endtask

    task automatic chk_log(input string name, input int good, input int nack_at);
        int exp_len;
        exp_len = good ? 8 : nack_at + 2;
        chk({name, "_len"}, log_q.size(), exp_len);
        for (int i = 0; i < log_q.size() && i < exp_len; i++) begin
            if (!good && i == exp_len - 1) chk({name, "_cmd"}, norm(log_q[i]), {C_STOP, 8'h00});
            else                          chk({name, "_cmd"}, norm(log_q[i]), norm(step_exp(i)));
        end
    endtask

    initial begin
        int s0, t0, w0, en_cyc, n;

        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;

        // idle, en=0, no trig: nothing happens
        repeat (1000) @(negedge clk);
        chk("no_wr_when_disabled", wr_count, 0);
        chk("busy_idle", busy, 0);

        // single triggered read with a second trig mid-sequence
        log_q.delete(); s0 = start_count; t0 = tv_count;
        slave_msb = 8'h0C; slave_lsb = 8'h80;
        pulse_trig();
        repeat (50) @(negedge clk);
        chk("busy_mid_seq", busy, 1);
        pulse_trig();
        wait_idle(1000);
        repeat (20) @(negedge clk);
        chk("t1_temp", temp, 16'h0C80);
        chk("t1_err", err, 0);
        chk("t1_one_seq", start_count - s0, 1);
        chk("t1_one_valid", tv_count - t0, 1);
        chk_log("t1_log", 1, 0);

        // slave NACKs the address byte
        log_q.delete(); t0 = tv_count; nack_wr = 1;
        pulse_trig();
        wait_idle(1000);
        chk("nack_err", err, 1);
        chk("nack_temp_held", temp, 16'h0C80);
        chk("nack_no_valid", tv_count - t0, 0);
        chk_log("nack_log", 0, 1);

        // next good read clears err
        nack_wr = 0; slave_msb = 8'h12; slave_lsb = 8'h34;
        pulse_trig();
        wait_idle(1000);
        chk("recover_temp", temp, 16'h1234);
        chk("recover_err", err, 0);

        // periodic polling from en
        w0 = wr_count; s0 = start_count; nack_rand = 1;
        @(negedge clk); en = 1'b1; en_cyc = cyc;
        n = 0;
        while (wr_count == w0 && n < 300) begin @(negedge clk); n++; end
        chk("first_auto_start_latency", cyc - en_cyc, 101);
        n = 0;
        while (start_count - s0 < 4 && n < 3000) begin
            @(negedge clk); n++;
            if (!busy) begin slave_msb = 8'($urandom); slave_lsb = 8'($urandom); end
        end
        chk("periodic_starts", start_count - s0 >= 4, 1);
        @(negedge clk); en = 1'b0;
        wait_idle(1000);

        // random mix of en / trig / NACKs
        for (int it = 0; it < 40; it++) begin
            @(negedge clk);
            en = 1'($urandom_range(0, 1));
            if (!busy) begin slave_msb = 8'($urandom); slave_lsb = 8'($urandom); end
            if ($urandom_range(0, 2) == 0) pulse_trig();
            repeat ($urandom_range(0, 350)) begin
                @(negedge clk);
                if (!busy) begin slave_msb = 8'($urandom); slave_lsb = 8'($urandom); end
            end
        end
        @(negedge clk); en = 1'b0; nack_rand = 0;
        wait_idle(1000);

        // reset during step 4, then a clean restart
        log_q.delete(); w0 = wr_count;
        pulse_trig();
        n = 0;
        while (wr_count - w0 < 5 && n < 1000) begin @(negedge clk); n++; end
        chk("reached_step4", log_q.size() >= 5 ? norm(log_q[4]) : 11'h0, {C_WR, 8'h97});
        @(negedge clk); #2 reset_n = 1'b0;
        #1 chk("async_reset_outputs", {m_wr, m_cmd, m_din, temp, temp_valid, err, busy}, 32'h0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        log_q.delete(); slave_msb = 8'hA5; slave_lsb = 8'h5A;
        pulse_trig();
        wait_idle(1000);
        chk("post_reset_temp", temp, 16'hA55A);
        chk_log("post_reset_log", 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
